// File: rtl/pp_seq.sv
// Program sequencer for the pP processor: owns the PC, the JSB/RET return stack
// and interrupt enable/entry. Next PC is combinational; all state commits on the rising edge.
module pp_seq #(
  parameter int          DEPTH    = 8,
  parameter logic [11:0] VECTOR   = 12'h004,
  parameter logic [11:0] RESET_PC = 12'h000,
  localparam int         AW       = $clog2(DEPTH),
  localparam int         SPW      = AW + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     kind,
  input  logic [7:0]     disp,
  input  logic [11:0]    addr,
  input  logic           br_taken,
  input  logic           stall,
  input  logic           irq,
  output logic [11:0]    pc,
  output logic           kill,
  output logic           int_ack,
  output logic           int_en,
  output logic           stk_err,
  output logic           ill,
  output logic [SPW-1:0] sp
);

  typedef enum logic [3:0] {
    K_RR    = 4'h0,
    K_RI    = 4'h1,
    K_SHIFT = 4'h2,
    K_MEMIO = 4'h3,
    K_BR    = 4'h4,
    K_JMP   = 4'h5,
    K_JSB   = 4'h6,
    K_RET   = 4'h7,
    K_RETI  = 4'h8,
    K_ENAI  = 4'h9,
    K_DISI  = 4'hA,
    K_ILL   = 4'hF
  } kind_e;

  logic [11:0]    pc_q, pc_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           int_en_q, int_en_d;
  logic           stk_err_q, stk_err_d;
  logic [11:0]    stk_q [DEPTH];

  logic           full, empty, take_int;
  logic           push, pop;
  logic [11:0]    push_val, pc_inc;
  logic [AW-1:0]  wr_idx, rd_idx;
  logic           kill_c, ack_c, ill_c;

  assign full     = (sp_q == SPW'(DEPTH));
  assign empty    = (sp_q == '0);
  assign take_int = irq && int_en_q && !full;
  assign pc_inc   = pc_q + 12'd1;
  assign wr_idx   = sp_q[AW-1:0];
  assign rd_idx   = wr_idx - AW'(1);

  always_comb begin
    pc_d      = pc_q;
    sp_d      = sp_q;
    int_en_d  = int_en_q;
    stk_err_d = stk_err_q;
    push      = 1'b0;
    pop       = 1'b0;
    push_val  = pc_q;
    kill_c    = 1'b0;
    ack_c     = 1'b0;
    ill_c     = 1'b0;
    if (!rst && !stall) begin
      if (take_int) begin
        // The current instruction is squashed and its own address becomes the return point.
        kill_c   = 1'b1;
        ack_c    = 1'b1;
        push     = 1'b1;
        push_val = pc_q;
        pc_d     = VECTOR;
        int_en_d = 1'b0;
      end else begin
        unique case (kind_e'(kind))
          K_BR:   pc_d = br_taken ? pc_q + {{4{disp[7]}}, disp} : pc_inc;
          K_JMP:  pc_d = addr;
          K_JSB: begin
            pc_d = addr;
            if (full) stk_err_d = 1'b1;
            else begin
              push     = 1'b1;
              push_val = pc_inc;
            end
          end
          K_RET, K_RETI: begin
            if (kind_e'(kind) == K_RETI) int_en_d = 1'b1;
            if (empty) begin
              pc_d      = pc_inc;
              stk_err_d = 1'b1;
            end else begin
              pop  = 1'b1;
              pc_d = stk_q[rd_idx];
            end
          end
          K_ENAI: begin
            int_en_d = 1'b1;
            pc_d     = pc_inc;
          end
          K_DISI: begin
            int_en_d = 1'b0;
            pc_d     = pc_inc;
          end
          K_ILL: begin
            ill_c = 1'b1;
            pc_d  = pc_inc;
          end
          default: pc_d = pc_inc;
        endcase
      end
      if (push) sp_d = sp_q + SPW'(1);
      if (pop)  sp_d = sp_q - SPW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      sp_q      <= '0;
      int_en_q  <= 1'b0;
      stk_err_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      sp_q      <= sp_d;
      int_en_q  <= int_en_d;
      stk_err_q <= stk_err_d;
      if (push) stk_q[wr_idx] <= push_val;
    end
  end

  assign pc      = pc_q;
  assign sp      = sp_q;
  assign int_en  = int_en_q;
  assign stk_err = stk_err_q;
  assign kill    = kill_c;
  assign int_ack = ack_c;
  assign ill     = ill_c;

endmodule

// File: tb/tb_pp_seq.sv
// Directed bench for pp_seq: each step drives one cycle, checks kill/int_ack/ill in that
// cycle, and queues the expected post-edge {pc, int_en, stk_err, sp} for checking after the edge.
module tb_pp_seq;

  localparam int SPW = 4;
  localparam int W   = 12 + 1 + 1 + SPW;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [3:0]     kind = '0;
  logic [7:0]     disp = '0;
  logic [11:0]    addr = '0;
  logic           br_taken = 1'b0;
  logic           stall = 1'b0;
  logic           irq = 1'b0;
  logic [11:0]    pc;
  logic           kill, int_ack, int_en, stk_err, ill;
  logic [SPW-1:0] sp;

  logic [W-1:0] exp_q[$];
  int compared   = 0;
  int mismatched = 0;

  pp_seq dut (
    .clk(clk), .rst(rst), .kind(kind), .disp(disp), .addr(addr),
    .br_taken(br_taken), .stall(stall), .irq(irq), .pc(pc), .kill(kill),
    .int_ack(int_ack), .int_en(int_en), .stk_err(stk_err), .ill(ill), .sp(sp)
  );

  always #5 clk = ~clk;

  task automatic step(input string tag, input logic [3:0] k, input logic [7:0] d,
                      input logic [11:0] a, input logic b, input logic st, input logic iq,
                      input logic r, input logic [2:0] exp_c, input logic [11:0] e_pc,
                      input logic e_en, input logic e_err, input logic [SPW-1:0] e_sp);
    logic [W-1:0] got, exp_v;
    @(negedge clk);
    kind = k; disp = d; addr = a; br_taken = b; stall = st; irq = iq; rst = r;
    #1;
    compared++;
    assert ({kill, int_ack, ill} === exp_c) else begin
      mismatched++;
      $display("FAIL %s comb {kill,ack,ill} got %b expected %b", tag, {kill, int_ack, ill}, exp_c);
      $error("comb check %s", tag);
    end
    exp_q.push_back({e_pc, e_en, e_err, e_sp});
    @(posedge clk);
    #1;
    got   = {pc, int_en, stk_err, sp};
    exp_v = exp_q.pop_front();
    compared++;
    assert (got === exp_v) else begin
      mismatched++;
      $display("FAIL %s state {pc,en,err,sp} got %h/%b/%b/%0d expected %h/%b/%b/%0d",
               tag, got[W-1 -: 12], got[SPW+1], got[SPW], got[SPW-1:0],
               exp_v[W-1 -: 12], exp_v[SPW+1], exp_v[SPW], exp_v[SPW-1:0]);
      $error("state check %s", tag);
    end
  endtask

  initial begin
    // Reset
    step("reset0", 4'h0, 8'h00, 12'h000, 0, 0, 0, 1, 3'b000, 12'h000, 0, 0, 0);
    step("reset1", 4'h0, 8'h00, 12'h000, 0, 0, 0, 1, 3'b000, 12'h000, 0, 0, 0);
    // Sequential kinds
    step("rr",     4'h0, 8'h00, 12'h000, 0, 0, 0, 0, 3'b000, 12'h001, 0, 0, 0);
    step("ri",     4'h1, 8'h00, 12'h000, 0, 0, 0, 0, 3'b000, 12'h002, 0, 0, 0);
    step("shift",  4'h2, 8'h00, 12'h000, 0, 0, 0, 0, 3'b000, 12'h003, 0, 0, 0);
    step("memio",  4'h3, 8'h00, 12'h000, 0, 0, 0, 0, 3'b000, 12'h004, 0, 0, 0);
    // Branches and wrap-around
    step("jmp010", 4'h5, 8'h00, 12'h010, 0, 0, 0, 0, 3'b000, 12'h010, 0, 0, 0);
    step("br_t",   4'h4, 8'hF8, 12'h000, 1, 0, 0, 0, 3'b000, 12'h008, 0, 0, 0);
    step("jmp010b",4'h5, 8'h00, 12'h010, 0, 0, 0, 0, 3'b000, 12'h010, 0, 0, 0);
    step("br_nt",  4'h4, 8'hF8, 12'h000, 0, 0, 0, 0, 3'b000, 12'h011, 0, 0, 0);
    step("jmp002", 4'h5, 8'h00, 12'h002, 0, 0, 0, 0, 3'b000, 12'h002, 0, 0, 0);
    step("br_wrap",4'h4, 8'hFC, 12'h000, 1, 0, 0, 0, 3'b000, 12'hFFE, 0, 0, 0);
    step("rr_fff", 4'h0, 8'h00, 12'h000, 0, 0, 0, 0, 3'b000, 12'hFFF, 0, 0, 0);
    step("rr_wrap",4'h0, 8'h00, 12'h000, 0, 0, 0, 0, 3'b000, 12'h000, 0, 0, 0);
    // Subroutine call/return
    step("jmp020", 4'h5, 8'h00, 12'h020, 0, 0, 0, 0, 3'b000, 12'h020, 0, 0, 0);
    step("jsb100", 4'h6, 8'h00, 12'h100, 0, 0, 0, 0, 3'b000, 12'h100, 0, 0, 1);
    step("ret",    4'h7, 8'h00, 12'h000, 0, 0, 0, 0, 3'b000, 12'h021, 0, 0, 0);
    // Fill the stack, then overflow
    for (int i = 0; i < 8; i++)
      step("jsb_fill", 4'h6, 8'h00, 12'h200 + 12'(i * 16), 0, 0, 0, 0, 3'b000,
           12'h200 + 12'(i * 16), 0, 0, 4'(i + 1));
    step("jsb_ovf",4'h6, 8'h00, 12'h300, 0, 0, 0, 0, 3'b000, 12'h300, 0, 1, 8);
    step("enai",   4'h9, 8'h00, 12'h000, 0, 0, 0, 0, 3'b000, 12'h301, 1, 1, 8);
    // Stalled with a pending interrupt and a full stack
    for (int i = 0; i < 3; i++)
      step("stall",  4'h6, 8'h00, 12'h555, 0, 1, 1, 0, 3'b000, 12'h301, 1, 1, 8);
    step("ret_full",4'h7, 8'h00, 12'h000, 0, 0, 1, 0, 3'b000, 12'h261, 1, 1, 7);
    step("int_defer",4'h0, 8'h00, 12'h000, 0, 0, 1, 0, 3'b110, 12'h004, 0, 1, 8);
    step("reti",   4'h8, 8'h00, 12'h000, 0, 0, 0, 0, 3'b000, 12'h261, 1, 1, 7);
    step("disi",   4'hA, 8'h00, 12'h000, 0, 0, 0, 0, 3'b000, 12'h262, 0, 1, 7);
    for (int i = 6; i >= 0; i--)
      step("unwind", 4'h7, 8'h00, 12'h000, 0, 0, 0, 0, 3'b000,
           (i == 0) ? 12'h022 : 12'h201 + 12'((i - 1) * 16), 0, 1, 4'(i));
    step("enai2",  4'h9, 8'h00, 12'h000, 0, 0, 0, 0, 3'b000, 12'h023, 1, 1, 0);
    // Reset overrides an interrupt take
    step("rst_int",4'h6, 8'h00, 12'h777, 0, 0, 1, 1, 3'b000, 12'h000, 0, 0, 0);
    step("ret_empty",4'h7, 8'h00, 12'h000, 0, 0, 0, 0, 3'b000, 12'h001, 0, 1, 0);
    step("illegal",4'hF, 8'h00, 12'h000, 0, 0, 0, 0, 3'b001, 12'h002, 0, 1, 0);
    // ENAI with irq held, RETI re-take
    step("jmp030", 4'h5, 8'h00, 12'h030, 0, 0, 1, 0, 3'b000, 12'h030, 0, 1, 0);
    step("enai_irq",4'h9, 8'h00, 12'h000, 0, 0, 1, 0, 3'b000, 12'h031, 1, 1, 0);
    step("int_take",4'h0, 8'h00, 12'h000, 0, 0, 1, 0, 3'b110, 12'h004, 0, 1, 1);
    step("reti_irq",4'h8, 8'h00, 12'h000, 0, 0, 1, 0, 3'b000, 12'h031, 1, 1, 0);
    step("int_retake",4'h6, 8'h00, 12'h123, 0, 0, 1, 0, 3'b110, 12'h004, 0, 1, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
